// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter/sequencer: data beats fetch, one access in flight, registered responses.
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_valid,
  output logic        o_if_stall,
  input  logic        i_flush,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_wstrb,
  input  logic        i_d_misaligned,
  output logic [31:0] o_d_rdata,
  output logic        o_d_valid,
  output logic        o_d_err,
  output logic        o_d_stall,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic [31:0] i_mem_rdata
);
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  if (MEM_LATENCY < 1 || STARVE_LIMIT < 1) begin : g_cfg_check
    $error("mem_port_arbiter: MEM_LATENCY and STARVE_LIMIT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_owner_d;   // 1: data owns the transaction, 0: fetch
  logic          r_we;
  logic          r_err;
  logic          r_drop;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_d_rdata;

  logic w_idle;
  logic w_fetch_ok;
  logic w_force_f;
  logic w_grant_d;
  logic w_grant_f;

  assign w_idle     = (r_state == IDLE) && !i_reset;
  assign w_fetch_ok = i_if_req && !i_flush;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;

  assign w_force_f = (r_starve == SW'(STARVE_LIMIT)) && w_fetch_ok;

  // Counts data grants that overtook a waiting fetch; any fetch grant resets it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_starve <= '0;
    end else if (w_grant_f) begin
      r_starve <= '0;
    end else if (w_grant_d && i_if_req && (r_starve != SW'(STARVE_LIMIT))) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  assign w_force_f = 1'b0;
`endif

  assign w_grant_d = w_idle && i_d_req && !w_force_f;
  assign w_grant_f = w_idle && w_fetch_ok && !w_grant_d;

  // RAM port is driven straight from the winner's inputs, only in the grant cycle.
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wstrb = '0;
    if (w_grant_d && !i_d_misaligned) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_d_we;
      o_mem_addr  = i_d_addr;
      o_mem_wdata = i_d_wdata;
      o_mem_wstrb = i_d_we ? i_d_wstrb : 4'b0000;
    end else if (w_grant_f) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_if_addr;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_next = i_d_misaligned ? RESP : WAIT;
        end else if (w_grant_f) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_owner_d  <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_drop     <= 1'b0;
      r_cnt      <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_grant_d || w_grant_f) begin
            r_owner_d <= w_grant_d;
            r_we      <= w_grant_d && i_d_we;
            r_err     <= w_grant_d && i_d_misaligned;
            r_cnt     <= CW'(MEM_LATENCY - 1);
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            // Stores leave the load data register untouched.
            if (!r_owner_d) begin
              r_if_rdata <= i_mem_rdata;
            end else if (!r_we) begin
              r_d_rdata <= i_mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
          if (i_flush && !r_owner_d) begin
            r_drop <= 1'b1;
          end
        end
        RESP:    r_drop <= 1'b0;
        default: r_drop <= 1'b0;
      endcase
    end
  end

  // A flush arriving in the response cycle itself also suppresses the fetch strobe.
  assign o_if_valid = (r_state == RESP) && !r_owner_d && !r_drop && !i_flush;
  assign o_d_valid  = (r_state == RESP) && r_owner_d;
  assign o_d_err    = o_d_valid && r_err;
  assign o_if_rdata = r_if_rdata;
  assign o_d_rdata  = r_d_rdata;
  assign o_if_stall = i_if_req && !o_if_valid;
  assign o_d_stall  = i_d_req && !o_d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reference model checks the MEM_LATENCY=1 instance every cycle,
// directed tests pin literal timings; a MEM_LATENCY=3 instance covers the flush redirect.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;
  localparam int LAT_A = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A (MEM_LATENCY=1) ----------------
  logic        a_if_req = 0, a_flush = 0, a_d_req = 0, a_d_we = 0, a_d_mis = 0;
  logic [31:0] a_if_addr = 0, a_d_addr = 0, a_d_wdata = 0;
  logic [3:0]  a_d_wstrb = 0;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_if_valid, a_if_stall, a_d_valid, a_d_err, a_d_stall, a_mem_en, a_mem_we;
  logic [3:0]  a_mem_wstrb;

  mem_port_arbiter #(.MEM_LATENCY(LAT_A), .STARVE_LIMIT(LIMIT)) u_dut_a (
    .i_clk(clk), .i_reset(rst),
    .i_if_req(a_if_req), .i_if_addr(a_if_addr), .o_if_rdata(a_if_rdata),
    .o_if_valid(a_if_valid), .o_if_stall(a_if_stall), .i_flush(a_flush),
    .i_d_req(a_d_req), .i_d_we(a_d_we), .i_d_addr(a_d_addr), .i_d_wdata(a_d_wdata),
    .i_d_wstrb(a_d_wstrb), .i_d_misaligned(a_d_mis), .o_d_rdata(a_d_rdata),
    .o_d_valid(a_d_valid), .o_d_err(a_d_err), .o_d_stall(a_d_stall),
    .o_mem_en(a_mem_en), .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr),
    .o_mem_wdata(a_mem_wdata), .o_mem_wstrb(a_mem_wstrb), .i_mem_rdata(a_mem_rdata)
  );

  // ---------------- DUT B (MEM_LATENCY=3), fetch only ----------------
  logic        b_if_req = 0, b_flush = 0, b_zero = 0;
  logic [31:0] b_if_addr = 0, b_zero32 = 0;
  logic [3:0]  b_zero4 = 0;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_if_valid, b_if_stall, b_d_valid, b_d_err, b_d_stall, b_mem_en, b_mem_we;
  logic [3:0]  b_mem_wstrb;

  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(LIMIT)) u_dut_b (
    .i_clk(clk), .i_reset(rst),
    .i_if_req(b_if_req), .i_if_addr(b_if_addr), .o_if_rdata(b_if_rdata),
    .o_if_valid(b_if_valid), .o_if_stall(b_if_stall), .i_flush(b_flush),
    .i_d_req(b_zero), .i_d_we(b_zero), .i_d_addr(b_zero32), .i_d_wdata(b_zero32),
    .i_d_wstrb(b_zero4), .i_d_misaligned(b_zero), .o_d_rdata(b_d_rdata),
    .o_d_valid(b_d_valid), .o_d_err(b_d_err), .o_d_stall(b_d_stall),
    .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr),
    .o_mem_wdata(b_mem_wdata), .o_mem_wstrb(b_mem_wstrb), .i_mem_rdata(b_mem_rdata)
  );

  // ---------------- RAM: shared contents, per-port read latency ----------------
  logic [31:0] ram [256];
  logic        ram_ready = 1'b0;
  logic [31:0] b_p0, b_p1, b_p2;

  function automatic logic [31:0] ram_init(input int i);
    logic [7:0] b;
    b = 8'(i);
    return (i == 'h10) ? 32'h00A00093 : {8'hA5, b, b, b};
  endfunction

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram[i] <= ram_init(i);
      ram_ready <= 1'b1;
    end else if (a_mem_en) begin
      a_mem_rdata <= ram[a_mem_addr[7:0]];
      if (a_mem_we) begin
        for (int bi = 0; bi < 4; bi++)
          if (a_mem_wstrb[bi]) ram[a_mem_addr[7:0]][8*bi +: 8] <= a_mem_wdata[8*bi +: 8];
      end
    end
  end

  always @(posedge clk) begin
    if (b_mem_en) b_p0 <= ram[b_mem_addr[7:0]];
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end
  assign b_mem_rdata = b_p2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- Reference model for DUT A ----------------
  // Transaction view: a grant starts a transaction whose response lands LAT_A+1 cycles
  // later (1 cycle for a misaligned rejection); nothing new is granted until it is done.
  bit          m_busy = 0, m_owner_d = 0, m_we = 0, m_err = 0, m_drop = 0;
  int          m_age = 0, m_resp_age = 0, m_starve = 0;
  logic [31:0] m_exp = 0, m_last_d = 0;

  always @(negedge clk) begin
    bit gd, gf, force_f, resp, e_en, e_we, e_ifv, e_dv;
    logic [31:0] e_addr;
    if (rst) begin
      m_busy = 0; m_drop = 0; m_starve = 0; m_last_d = '0;
    end
    gd = 0; gf = 0;
    if (!rst && !m_busy) begin
`ifdef ARB_STARVE_GUARD_EN
      force_f = (m_starve == LIMIT) && a_if_req && !a_flush;
`else
      force_f = 0;
`endif
      gd = a_d_req && !force_f;
      gf = !gd && a_if_req && !a_flush;
    end
    resp   = m_busy && (m_age == m_resp_age);
    e_en   = (gd && !a_d_mis) || gf;
    e_we   = gd && !a_d_mis && a_d_we;
    e_addr = gd ? a_d_addr : a_if_addr;
    e_ifv  = resp && !m_owner_d && !m_drop && !a_flush;
    e_dv   = resp && m_owner_d;

    chk("mem_en", a_mem_en, e_en);
    if (e_en) begin
      chk("mem_we", a_mem_we, e_we);
      chk("mem_addr", a_mem_addr, e_addr);
      chk("mem_wstrb", a_mem_wstrb, e_we ? a_d_wstrb : 4'b0000);
      if (e_we) chk("mem_wdata", a_mem_wdata, a_d_wdata);
    end
    chk("if_valid", a_if_valid, e_ifv);
    chk("d_valid", a_d_valid, e_dv);
    chk("d_err", a_d_err, e_dv && m_err);
    chk("if_stall", a_if_stall, a_if_req && !e_ifv);
    chk("d_stall", a_d_stall, a_d_req && !e_dv);
    if (e_ifv) chk("if_rdata", a_if_rdata, m_exp);
    if (e_dv)  chk("d_rdata", a_d_rdata, (m_we || m_err) ? m_last_d : m_exp);

    if (m_busy) begin
      if (a_flush && !m_owner_d) m_drop = 1;
      if (resp) begin
        if (m_owner_d && !m_we && !m_err) m_last_d = m_exp;
        m_busy = 0; m_drop = 0;
      end else begin
        m_age++;
      end
    end else if (gd || gf) begin
      m_busy = 1; m_age = 1; m_owner_d = gd;
      m_we = gd && a_d_we; m_err = gd && a_d_mis;
      m_resp_age = (gd && a_d_mis) ? 1 : LAT_A + 1;
      m_exp = ram[e_addr[7:0]];
      if (gf) m_starve = 0;
      else if (a_if_req && m_starve < LIMIT) m_starve++;
    end
  end

  // ---------------- Directed transaction tasks for DUT A ----------------
  task automatic a_fetch(input logic [31:0] addr, output int tg, output int td,
                         output logic [31:0] rd);
    @(posedge clk); #1;
    a_if_req = 1; a_if_addr = addr;
    tg = -1; td = -1; rd = '0;
    for (int k = 0; k < 40 && td < 0; k++) begin
      @(negedge clk);
      if (a_mem_en && !a_mem_we && a_mem_addr == addr && tg < 0) tg = cyc;
      if (a_if_valid) begin td = cyc; rd = a_if_rdata; end
    end
    @(posedge clk); #1;
    a_if_req = 0;
    chk("fetch_completed", td >= 0, 1);
    $display("fetch addr=0x%08h grant=%0d done=%0d rdata=0x%08h", addr, tg, td, rd);
  endtask

  task automatic a_data(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic mis,
                        output int ts, output int tg, output int td, output logic [31:0] rd,
                        output logic err, output logic gwe, output logic [3:0] gstrb,
                        output logic [31:0] gwd);
    @(posedge clk); #1;
    a_d_req = 1; a_d_we = we; a_d_addr = addr; a_d_wdata = wd; a_d_wstrb = strb; a_d_mis = mis;
    ts = -1; tg = -1; td = -1; rd = '0; err = 0; gwe = 0; gstrb = '0; gwd = '0;
    for (int k = 0; k < 40 && td < 0; k++) begin
      @(negedge clk);
      if (ts < 0) ts = cyc;
      if (a_mem_en && a_mem_addr == addr && tg < 0) begin
        tg = cyc; gwe = a_mem_we; gstrb = a_mem_wstrb; gwd = a_mem_wdata;
      end
      if (a_d_valid) begin td = cyc; rd = a_d_rdata; err = a_d_err; end
    end
    @(posedge clk); #1;
    a_d_req = 0; a_d_mis = 0;
    chk("data_completed", td >= 0, 1);
    $display("data we=%0b addr=0x%08h start=%0d grant=%0d done=%0d rdata=0x%08h err=%0b",
             we, addr, ts, tg, td, rd, err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tg, td, tgf, tdf, ts, nf, nd, cnt, g2, vd, early, t0;
    logic [31:0] rd, rdf, gwd;
    logic err, gwe;
    logic [3:0] gstrb;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_if_valid", a_if_valid, 0);
    chk("rst_d_valid", a_d_valid, 0);
    chk("rst_d_err", a_d_err, 0);
    chk("rst_mem_en", a_mem_en, 0);
    chk("rst_if_rdata", a_if_rdata, 0);
    chk("rst_d_rdata", a_d_rdata, 0);
    @(posedge clk); #1;
    rst = 0;

    // Single fetch: valid two cycles after the grant
    a_fetch(32'h10, tg, td, rd);
    chk("fetch_latency", td - tg, 2);
    chk("fetch_rdata", rd, 32'h00A00093);

    // Simultaneous requests: data first, fetch granted the cycle after data RESP
    fork
      a_data(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, ts, tg, td, rd, err, gwe, gstrb, gwd);
      a_fetch(32'h20, tgf, tdf, rdf);
    join
    chk("sim_load_grant", tg, ts);
    chk("sim_load_done", td - tg, 2);
    chk("sim_load_rdata", rd, 32'hA5000000);
    chk("sim_fetch_grant", tgf - tg, 3);
    chk("sim_fetch_done", tdf - tg, 5);
    chk("sim_fetch_rdata", rdf, 32'hA5202020);

    // Store then read back
    a_data(1'b1, 32'h204, 32'h0000BEEF, 4'b0011, 1'b0, ts, tg, td, rd, err, gwe, gstrb, gwd);
    chk("store_we", gwe, 1);
    chk("store_strb", gstrb, 4'b0011);
    chk("store_wdata", gwd, 32'h0000BEEF);
    chk("store_done", td - tg, 2);
    chk("store_rdata_held", rd, 32'hA5000000);
    a_data(1'b0, 32'h204, 32'h0, 4'h0, 1'b0, ts, tg, td, rd, err, gwe, gstrb, gwd);
    chk("readback", rd, 32'hA504BEEF);

    // Misaligned load: no RAM access, error response next cycle
    a_data(1'b0, 32'h102, 32'h0, 4'h0, 1'b1, ts, tg, td, rd, err, gwe, gstrb, gwd);
    chk("mis_no_mem_en", tg, -1);
    chk("mis_done", td - ts, 1);
    chk("mis_err", err, 1);

    // Flush in IDLE blocks the fetch grant for that cycle only
    @(posedge clk); #1;
    a_if_req = 1; a_if_addr = 32'h28; a_flush = 1;
    @(negedge clk);
    chk("idle_flush_blocks", a_mem_en, 0);
    @(posedge clk); #1;
    a_flush = 0;
    @(negedge clk);
    chk("idle_flush_release", a_mem_en, 1);
    td = -1;
    for (int k = 0; k < 10 && td < 0; k++) begin
      @(negedge clk);
      if (a_if_valid) td = cyc;
    end
    @(posedge clk); #1;
    a_if_req = 0;
    chk("idle_flush_fetch_done", td >= 0, 1);
    $display("fetch addr=0x00000028 after idle flush done=%0d", td);

    // Reset in the middle of a fetch abandons it
    @(posedge clk); #1;
    a_if_req = 1; a_if_addr = 32'h24;
    @(posedge clk); #1;
    rst = 1; a_if_req = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_if_valid) cnt++;
    end
    chk("reset_abandon", cnt, 0);
    $display("fetch addr=0x00000024 abandoned by reset");

    // Continuous data and fetch requests
    @(posedge clk); #1;
    a_d_req = 1; a_d_we = 0; a_d_addr = 32'h80; a_d_mis = 0;
    a_if_req = 1; a_if_addr = 32'h40;
    nf = 0; nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (a_mem_en && a_mem_addr == 32'h40) nf++;
      if (a_mem_en && a_mem_addr == 32'h80) nd++;
    end
    @(posedge clk); #1;
    a_d_req = 0; a_if_req = 0;
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_fetch_grants", nf, 2);
    chk("starve_data_grants", nd, 8);
`else
    chk("strict_fetch_grants", nf, 0);
    chk("strict_data_grants", nd, 10);
`endif
    $display("contention window: data grants=%0d fetch grants=%0d", nd, nf);

    // Flush during fetch WAIT on the MEM_LATENCY=3 instance
    @(posedge clk); #1;
    b_if_req = 1; b_if_addr = 32'h30;
    @(negedge clk);
    t0 = cyc;
    chk("b_grant_en", b_mem_en, 1);
    chk("b_grant_addr", b_mem_addr, 32'h30);
    @(posedge clk); #1;
    b_flush = 1; b_if_addr = 32'h50;
    @(posedge clk); #1;
    b_flush = 0;
    g2 = -1; vd = -1; early = 0; rd = '0;
    for (int k = 0; k < 30 && vd < 0; k++) begin
      @(negedge clk);
      if (b_mem_en && b_mem_addr == 32'h50 && g2 < 0) g2 = cyc;
      if (b_if_valid) begin
        if (g2 < 0) early++;
        else begin vd = cyc; rd = b_if_rdata; end
      end
    end
    @(posedge clk); #1;
    b_if_req = 0;
    chk("b_dropped_valid", early, 0);
    chk("b_regrant", g2 - t0, 5);
    chk("b_latency", vd - g2, 4);
    chk("b_rdata", rd, 32'hA5505050);
    $display("fetch(L=3) flushed 0x30 at %0d, regrant 0x50 at %0d, done %0d rdata=0x%08h",
             t0, g2, vd, rd);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
